// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: aligns an MSB-first bit stream to byte boundaries
// using a comma word, then presents every non-comma byte on data_out.
module serial_to_parallel_rx #(
    parameter logic [7:0] COMMA    = 8'hBC,
    parameter int         LOCK_CNT = 4,
    parameter int         MAX_GAP  = 32
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam int GW = $clog2(MAX_GAP + 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(MAX_GAP - 1);

    typedef enum logic [1:0] {SEARCH, LOCKING, SYNC} state_t;

    state_t        state_q, state_d;
    logic [6:0]    sr_q, sr_d;          // previous 7 bits; with data_in they form the 8-bit window
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    fill_q, fill_d;
    logic [CW-1:0] comma_cnt_q, comma_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          active_q, active_d;

    logic [7:0] cand;
    logic       boundary;
    logic       window_full;

    assign cand        = {sr_q, data_in};
    assign boundary    = (bit_cnt_q == 3'd7);
    assign window_full = (fill_q == 3'd7);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        sr_d        = cand[6:0];
        bit_cnt_d   = bit_cnt_q + 3'd1;
        fill_d      = window_full ? fill_q : fill_q + 3'd1;
        comma_cnt_d = comma_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;

        case (state_q)
            SEARCH: begin
                bit_cnt_d   = 3'd0;
                comma_cnt_d = '0;
                gap_cnt_d   = '0;
                if (window_full && cand == COMMA) begin
                    state_d     = LOCKING;
                    comma_cnt_d = CW'(1);
                end
            end
            LOCKING: begin
                if (boundary) begin
                    if (cand == COMMA) begin
                        if (comma_cnt_q == LOCK_LAST) begin
                            state_d     = SYNC;
                            comma_cnt_d = '0;
                            gap_cnt_d   = '0;
                        end else begin
                            comma_cnt_d = comma_cnt_q + CW'(1);
                        end
                    end else begin
                        state_d     = SEARCH;
                        comma_cnt_d = '0;
                    end
                end
            end
            SYNC: begin
                // Alignment is frozen here: commas at other bit offsets are never looked at.
                if (boundary) begin
                    if (cand == COMMA) begin
                        gap_cnt_d = '0;
                    end else begin
                        data_d  = cand;
                        valid_d = 1'b1;
                        if (gap_cnt_q == GAP_LAST) begin
                            state_d   = SEARCH;
                            gap_cnt_d = '0;
                            bit_cnt_d = 3'd0;
                        end else begin
                            gap_cnt_d = gap_cnt_q + GW'(1);
                        end
                    end
                end
            end
            default: state_d = SEARCH;
        endcase

        active_d = (state_d == SYNC);
    end

    // NOTE: sequential state uses non-blocking assignments only; all _d values come from the comb block.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            fill_q      <= '0;
            comma_cnt_q <= '0;
            gap_cnt_q   <= '0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            fill_q      <= fill_d;
            comma_cnt_q <= comma_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx: reset, aligned and misaligned lock,
// failed lock, loss of sync after MAX_GAP data bytes, and reset mid-stream.
module tb_serial_to_parallel_rx;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int checks = 0;
    int errors = 0;

    int bit_idx;
    int valid_cnt;
    int last_valid_bit;
    int rise_bit;
    int fall_bit;
    logic prev_active;

    serial_to_parallel_rx #(
        .COMMA    (8'hBC),
        .LOCK_CNT (4),
        .MAX_GAP  (32)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        bit_idx        = 0;
        valid_cnt      = 0;
        last_valid_bit = -1;
        rise_bit       = -1;
        fall_bit       = -1;
        prev_active    = active;
    endtask

    // Drive one bit, let the rising edge take it, then sample outputs 1 ns later.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        bit_idx++;
        if (valid_out) begin
            valid_cnt++;
            last_valid_bit = bit_idx;
        end
        if (active && !prev_active) rise_bit = bit_idx;
        if (!active && prev_active) fall_bit = bit_idx;
        prev_active = active;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) begin
            data_in = 1'($urandom);
            @(posedge clk_32f);
            #1;
        end
        reset = 1'b1;
        clear_stats();
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;
        #2;

        // Reset held for 5 cycles with random data: outputs stay clear every cycle.
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            data_in = 1'($urandom);
            @(posedge clk_32f);
            #1;
            check("rst_data_out", 32'(data_out), 32'h00);
            check("rst_valid",    32'(valid_out), 32'h0);
            check("rst_active",   32'(active), 32'h0);
        end
        reset = 1'b1;
        clear_stats();

        // Aligned lock: active rises on bit 32, no valid pulses while locking.
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        check("lock_active_before_4th", 32'(active), 32'h0);
        send_byte(8'hBC);
        check("lock_rise_bit", 32'(rise_bit), 32'd32);
        check("lock_no_valid", 32'(valid_cnt), 32'd0);
        check("lock_data_held", 32'(data_out), 32'h00);

        // First data byte in SYNC.
        clear_stats();
        send_byte(8'hA5);
        check("sync_a5_data", 32'(data_out), 32'hA5);
        check("sync_a5_valid_cnt", 32'(valid_cnt), 32'd1);
        check("sync_a5_valid_bit", 32'(last_valid_bit), 32'd8);
        send_bit(1'b1);
        check("sync_valid_one_cycle", 32'(valid_out), 32'h0);
        for (int i = 0; i < 7; i++) send_bit(1'b0);

        // A comma after 31 data bytes resets the gap count and keeps sync.
        clear_stats();
        send_byte(8'hBC);
        check("comma_no_valid", 32'(valid_cnt), 32'd0);
        check("comma_data_held", 32'(data_out), 32'h80);
        for (int k = 0; k < 31; k++) send_byte(8'h3C);
        send_byte(8'hBC);
        check("gap31_valid_cnt", 32'(valid_cnt), 32'd31);
        check("gap31_active", 32'(active), 32'h1);

        // 32 consecutive data bytes drop sync on the last one, which is still presented.
        clear_stats();
        for (int k = 0; k < 32; k++) send_byte(8'h3C);
        check("gap32_valid_cnt", 32'(valid_cnt), 32'd32);
        check("gap32_fall_bit", 32'(fall_bit), 32'd256);
        check("gap32_last_valid_bit", 32'(last_valid_bit), 32'd256);
        check("gap32_data", 32'(data_out), 32'h3C);
        clear_stats();
        for (int k = 0; k < 2; k++) send_byte(8'h3C);
        check("search_no_valid", 32'(valid_cnt), 32'd0);
        check("search_active", 32'(active), 32'h0);

        // Misaligned lock: 3 random bits, then 5 commas and a data byte.
        do_reset(2);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        for (int k = 0; k < 5; k++) send_byte(8'hBC);
        check("mis_rise_bit", 32'(rise_bit), 32'd35);
        check("mis_no_valid", 32'(valid_cnt), 32'd0);
        send_byte(8'hA5);
        check("mis_a5_data", 32'(data_out), 32'hA5);
        check("mis_a5_valid_cnt", 32'(valid_cnt), 32'd1);
        check("mis_a5_valid_bit", 32'(last_valid_bit), 32'd51);

        // Failed lock: BC BC BC 55 falls back to SEARCH, then 4 commas lock.
        do_reset(2);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        send_byte(8'h55);
        check("fail_active", 32'(active), 32'h0);
        check("fail_no_valid", 32'(valid_cnt), 32'd0);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        check("relock_not_yet", 32'(active), 32'h0);
        send_byte(8'hBC);
        check("relock_rise_bit", 32'(rise_bit), 32'd64);
        check("relock_no_valid", 32'(valid_cnt), 32'd0);

        // Reset asserted asynchronously during the 4th bit of a byte in SYNC.
        send_byte(8'h5A);
        check("pre_rst_data", 32'(data_out), 32'h5A);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        data_in = 1'b1;
        @(negedge clk_32f);
        reset = 1'b0;
        #1;
        check("async_rst_data", 32'(data_out), 32'h00);
        check("async_rst_valid", 32'(valid_out), 32'h0);
        check("async_rst_active", 32'(active), 32'h0);
        @(posedge clk_32f);
        #1;
        reset = 1'b1;
        clear_stats();
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        check("post_rst_partial", 32'(active), 32'h0);
        send_byte(8'hBC);
        check("post_rst_rise_bit", 32'(rise_bit), 32'd32);
        check("post_rst_no_valid", 32'(valid_cnt), 32'd0);
        check("post_rst_data", 32'(data_out), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_rx.md
SERIAL_TO_PARALLEL_RX -- requirements
Module: serial_to_parallel_rx

Interface
REQ-001 Parameter COMMA, default 8'hBC, meaning idle/comma word used for byte alignment.
REQ-002 Parameter LOCK_CNT, default 4, meaning consecutive aligned COMMA words required to declare sync.
REQ-003 Parameter MAX_GAP, default 32, meaning consecutive non-COMMA bytes in SYNC that force loss of sync.
REQ-004 clk_32f  input  1  serial bit clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  1  serial bit stream, MSB of each byte first, one bit per clk_32f cycle.
REQ-007 data_out  output  8  last received non-COMMA byte, registered.
REQ-008 valid_out  output  1  one-cycle strobe, data_out newly updated.
REQ-009 active  output  1  receiver in SYNC, byte alignment established.

Function
REQ-010 Block SHALL shift data_in into an 8-bit register each cycle: sr <= {sr[6:0], data_in}; candidate byte = {sr[6:0], data_in}.
REQ-011 Block SHALL implement three states: SEARCH, LOCKING, SYNC.
REQ-012 SEARCH: candidate byte compared every cycle; on candidate == COMMA -> LOCKING, bit counter cleared to 0, comma count = 1.
REQ-013 LOCKING/SYNC: 3-bit bit counter SHALL increment every cycle and wrap 7 -> 0; byte boundary = cycle where counter == 7 (8th bit after previous boundary).
REQ-014 LOCKING, at boundary, candidate == COMMA: comma count increments; if new count == LOCK_CNT -> SYNC and active = 1 on the same edge.
REQ-015 LOCKING, at boundary, candidate != COMMA: -> SEARCH, comma count = 0, active stays 0.
REQ-016 LOCKING SHALL NOT update data_out or assert valid_out.
REQ-017 SYNC, at boundary, candidate == COMMA: gap count cleared, valid_out = 0, data_out held.
REQ-018 SYNC, at boundary, candidate != COMMA: data_out = candidate, valid_out = 1 for exactly one cycle, gap count increments.
REQ-019 SYNC, gap count reaching MAX_GAP: -> SEARCH, active = 0 on that edge; that byte still presented on data_out with valid_out.
REQ-020 valid_out SHALL be 0 on every non-boundary cycle and in SEARCH/LOCKING.
REQ-021 Latency: data_out/valid_out/active SHALL change on the edge that samples the LSB of the qualifying byte (registered, visible the following cycle).
REQ-022 Gap counter width SHALL be ceil(log2(MAX_GAP+1)) bits, saturating never required (cleared on exit).
REQ-023 SEARCH SHALL not match on partial bytes: first 7 cycles after reset are ignored for comparison.
REQ-024 COMMA arriving in SYNC at a non-boundary bit offset SHALL be ignored (alignment not re-acquired while in SYNC).

Reset
REQ-025 reset low SHALL asynchronously force: state SEARCH, sr = 0, counters = 0, data_out = 8'h00, valid_out = 0, active = 0.
REQ-026 reset deassertion mid-stream SHALL restart alignment from SEARCH; no output derived from pre-reset bits.

Verification
REQ-027 Reset: hold reset low 5 cycles with random data_in -> data_out = 00, valid_out = 0, active = 0 throughout.
REQ-028 Lock: after reset send 4 x BC aligned -> active rises on edge sampling LSB of 4th BC (bit 32), valid_out never asserted.
REQ-029 Misaligned lock: 3 random bits then 5 x BC -> active rises on LSB of 4th BC following first match; subsequent A5 -> data_out = A5, valid_out high one cycle.
REQ-030 Failed lock: BC, BC, BC, 55 -> returns to SEARCH, active stays 0, no valid_out; then 4 x BC -> active = 1.
REQ-031 Loss of sync: in SYNC send 32 x 3C -> 32 valid_out pulses, active falls on LSB of 32nd byte; a BC after 31 bytes instead keeps active = 1.
REQ-032 Reset mid-operation: in SYNC during 4th bit of a byte pull reset low -> all outputs 0 immediately, relock requires fresh 4 x BC.
